// File: rtl/snake_body_tracker.sv
// snake_body_tracker: owns the snake body, steps it one segment per game tick,
// grows it after an apple is eaten and flags wall and self collisions.
module snake_body_tracker #(
  parameter int SegWidth        = 10,
  parameter int SegHeight       = 10,
  parameter int AppleWidth      = 10,
  parameter int AppleHeight     = 10,
  parameter int BorderThickness = 10,
  parameter int DisplayWidth    = 240,
  parameter int DisplayHeight   = 320,
  parameter int MaxSize         = 128
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   gameTick,
  input  logic [1:0]             direction,
  input  logic [7:0]             appleLocX,
  input  logic [8:0]             appleLocY,
  output logic [MaxSize*8-1:0]   snakeLocX,
  output logic [MaxSize*9:0]     snakeLocY,
  output logic [7:0]             size,
  output logic                   appleEaten,
  output logic                   gameOver,
  output logic                   busy
);

  localparam logic [9:0] XMin = 10'(BorderThickness);
  localparam logic [9:0] XMax = 10'(DisplayWidth - BorderThickness - SegWidth);
  localparam logic [9:0] YMin = 10'(BorderThickness);
  localparam logic [9:0] YMax = 10'(DisplayHeight - BorderThickness - SegHeight);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_EAT  = 2'd2,
    ST_SCAN = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  dir_q, dir_d;
  logic        grow_q, grow_d;
  logic [7:0]  size_q, size_d;
  logic [6:0]  k_q, k_d;
  logic [7:0]  seg_x_q [MaxSize];
  logic [7:0]  seg_x_d [MaxSize];
  logic [8:0]  seg_y_q [MaxSize];
  logic [8:0]  seg_y_d [MaxSize];
  logic        eaten_q, eaten_d;
  logic        over_q, over_d;
  logic        busy_q, busy_d;

  logic [9:0]  new_x, new_y;
  logic [7:0]  new_size;
  logic        head_hits_apple;

  // Two 1-D spans [lo, lo+len) overlap when each starts before the other ends.
  function automatic logic spans_overlap(input logic [9:0] a_lo, input logic [9:0] a_len,
                                         input logic [9:0] b_lo, input logic [9:0] b_len);
    spans_overlap = (a_lo < (b_lo + b_len)) && (b_lo < (a_lo + a_len));
  endfunction

  // Candidate head position one step from the current head, at 10-bit width.
  always_comb begin
    new_x = {2'b00, seg_x_q[0]};
    new_y = {1'b0, seg_y_q[0]};
    case (dir_q)
      2'b00:   new_y = {1'b0, seg_y_q[0]} - 10'(SegHeight);
      2'b01:   new_y = {1'b0, seg_y_q[0]} + 10'(SegHeight);
      2'b10:   new_x = {2'b00, seg_x_q[0]} - 10'(SegWidth);
      2'b11:   new_x = {2'b00, seg_x_q[0]} + 10'(SegWidth);
      default: new_x = {2'b00, seg_x_q[0]};
    endcase
  end

  // Head box against apple box on both axes.
  always_comb begin
    head_hits_apple =
      spans_overlap({2'b00, seg_x_q[0]}, 10'(SegWidth), {2'b00, appleLocX}, 10'(AppleWidth)) &&
      spans_overlap({1'b0, seg_y_q[0]}, 10'(SegHeight), {1'b0, appleLocY}, 10'(AppleHeight));
  end

  // Next-state logic for the tick FSM and the segment store.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    grow_d   = grow_q;
    size_d   = size_q;
    k_d      = k_q;
    seg_x_d  = seg_x_q;
    seg_y_d  = seg_y_q;
    eaten_d  = 1'b0;
    over_d   = over_q;
    new_size = size_q;
    case (state_q)
      ST_IDLE: begin
        if (gameTick && !over_q) begin
          state_d = ST_MOVE;
          // A direct reversal keeps the old heading; other turns are taken.
          if ((direction[1] == dir_q[1]) && (direction[0] != dir_q[0])) begin
            dir_d = dir_q;
          end else begin
            dir_d = direction;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MOVE: begin
        if ((new_x < XMin) || (new_x > XMax) || (new_y < YMin) || (new_y > YMax)) begin
          over_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          if (grow_q) begin
            grow_d = 1'b0;
            if (size_q < 8'(MaxSize)) begin
              new_size = size_q + 8'd1;
            end else begin
              new_size = size_q;
            end
          end else begin
            new_size = size_q;
          end
          size_d = new_size;
          for (int i = 1; i < MaxSize; i++) begin
            if (i < int'(new_size)) begin
              seg_x_d[i] = seg_x_q[i-1];
              seg_y_d[i] = seg_y_q[i-1];
            end else begin
              seg_x_d[i] = 8'd0;
              seg_y_d[i] = 9'd0;
            end
          end
          seg_x_d[0] = new_x[7:0];
          seg_y_d[0] = new_y[8:0];
          state_d    = ST_EAT;
        end
      end
      ST_EAT: begin
        if (head_hits_apple) begin
          eaten_d = 1'b1;
          grow_d  = 1'b1;
        end else begin
          eaten_d = 1'b0;
        end
        k_d = 7'd1;
        if (size_q > 8'd1) begin
          state_d = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if ((seg_x_q[k_q] == seg_x_q[0]) && (seg_y_q[k_q] == seg_y_q[0])) begin
          over_d  = 1'b1;
          state_d = ST_IDLE;
        end else if ({1'b0, k_q} == (size_q - 8'd1)) begin
          state_d = ST_IDLE;
        end else begin
          k_d = k_q + 7'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset to the starting snake.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dir_q   <= 2'b01;
      grow_q  <= 1'b0;
      size_q  <= 8'd3;
      k_q     <= 7'd1;
      eaten_q <= 1'b0;
      over_q  <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < MaxSize; i++) begin
        seg_x_q[i] <= 8'd0;
        seg_y_q[i] <= 9'd0;
      end
      seg_x_q[0] <= 8'd50;
      seg_y_q[0] <= 9'd50;
      seg_x_q[1] <= 8'd50;
      seg_y_q[1] <= 9'd40;
      seg_x_q[2] <= 8'd50;
      seg_y_q[2] <= 9'd30;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      grow_q  <= grow_d;
      size_q  <= size_d;
      k_q     <= k_d;
      eaten_q <= eaten_d;
      over_q  <= over_d;
      busy_q  <= busy_d;
      seg_x_q <= seg_x_d;
      seg_y_q <= seg_y_d;
    end
  end

  // Pack the segment store onto the flat position buses; the Y spare bit stays 0.
  always_comb begin
    snakeLocX = '0;
    snakeLocY = '0;
    for (int i = 0; i < MaxSize; i++) begin
      snakeLocX[i*8 +: 8] = seg_x_q[i];
      snakeLocY[i*9 +: 9] = seg_y_q[i];
    end
  end

  assign size       = size_q;
  assign appleEaten = eaten_q;
  assign gameOver   = over_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_snake_body_tracker.sv
// Bench for snake_body_tracker: directed scenarios plus randomized ticks checked
// against a queue-based model of the snake.
module tb_snake_body_tracker;

  logic          clock;
  logic          reset;
  logic          gameTick;
  logic [1:0]    direction;
  logic [7:0]    appleLocX;
  logic [8:0]    appleLocY;
  logic [1023:0] snakeLocX;
  logic [1152:0] snakeLocY;
  logic [7:0]    size;
  logic          appleEaten;
  logic          gameOver;
  logic          busy;

  int total = 0;
  int bad   = 0;

  // Reference model: head at index 0.
  int         mx[$];
  int         my[$];
  logic [1:0] m_dir;
  bit         m_grow;
  bit         m_over;

  snake_body_tracker dut (
    .clock      (clock),
    .reset      (reset),
    .gameTick   (gameTick),
    .direction  (direction),
    .appleLocX  (appleLocX),
    .appleLocY  (appleLocY),
    .snakeLocX  (snakeLocX),
    .snakeLocY  (snakeLocY),
    .size       (size),
    .appleEaten (appleEaten),
    .gameOver   (gameOver),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_reset();
    mx = {50, 50, 50};
    my = {50, 40, 30};
    m_dir  = 2'b01;
    m_grow = 1'b0;
    m_over = 1'b0;
  endtask

  task automatic model_tick(input logic [1:0] dir, input int ax, input int ay,
                            output int exp_busy, output int exp_eat);
    int nx, ny;
    exp_busy = 0;
    exp_eat  = 0;
    if (m_over) return;
    if ((dir ^ m_dir) != 2'b01) m_dir = dir;
    nx = mx[0];
    ny = my[0];
    case (m_dir)
      2'd0:    ny = ny - 10;
      2'd1:    ny = ny + 10;
      2'd2:    nx = nx - 10;
      default: nx = nx + 10;
    endcase
    if (nx < 10 || nx > 220 || ny < 10 || ny > 300) begin
      m_over   = 1'b1;
      exp_busy = 1;
      return;
    end
    mx.push_front(nx);
    my.push_front(ny);
    if (m_grow && mx.size() <= 128) begin
      m_grow = 1'b0;
    end else begin
      m_grow = 1'b0;
      void'(mx.pop_back());
      void'(my.pop_back());
    end
    if (nx < ax + 10 && ax < nx + 10 && ny < ay + 10 && ay < ny + 10) begin
      exp_eat = 1;
      m_grow  = 1'b1;
    end
    exp_busy = 1 + mx.size();
    for (int k = 1; k < mx.size(); k++) begin
      if (mx[k] == nx && my[k] == ny) begin
        m_over   = 1'b1;
        exp_busy = 2 + k;
        break;
      end
    end
  endtask

  function automatic logic [1023:0] exp_x();
    logic [1023:0] v;
    v = '0;
    for (int i = 0; i < mx.size(); i++) v[i*8 +: 8] = 8'(mx[i]);
    return v;
  endfunction

  function automatic logic [1152:0] exp_y();
    logic [1152:0] v;
    v = '0;
    for (int i = 0; i < my.size(); i++) v[i*9 +: 9] = 9'(my[i]);
    return v;
  endfunction

  task automatic apply_reset();
    reset    = 1'b1;
    gameTick = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  // Pulse one tick and measure how long busy stays high and how many eat pulses appear.
  task automatic do_tick(input logic [1:0] dir, input int ax, input int ay, input bit dup,
                         output int busy_cnt, output int eat_cnt);
    int guard;
    direction = dir;
    appleLocX = 8'(ax);
    appleLocY = 9'(ay);
    gameTick  = 1'b1;
    @(negedge clock);
    gameTick = 1'b0;
    busy_cnt = 0;
    eat_cnt  = 0;
    guard    = 0;
    while (busy === 1'b1 && guard < 300) begin
      busy_cnt++;
      if (appleEaten === 1'b1) eat_cnt++;
      guard++;
      gameTick = (dup && guard == 1);
      @(negedge clock);
    end
    gameTick = 1'b0;
    if (appleEaten === 1'b1) eat_cnt++;
    @(negedge clock);
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (size !== 8'd3) begin bad++; $display("FAIL reset_size: got %0d want 3", size); end
    total++;
    if (snakeLocX[23:0] !== {8'd50, 8'd50, 8'd50}) begin
      bad++; $display("FAIL reset_x: got %h want 323232", snakeLocX[23:0]);
    end
    total++;
    if (snakeLocY[26:0] !== {9'd30, 9'd40, 9'd50}) begin
      bad++; $display("FAIL reset_y: got %h want %h", snakeLocY[26:0], {9'd30, 9'd40, 9'd50});
    end
    total++;
    if (snakeLocX[1023:24] !== '0 || snakeLocY[1152:27] !== '0) begin
      bad++; $display("FAIL reset_upper: got nonzero upper slots want 0");
    end
    total++;
    if (gameOver !== 1'b0 || busy !== 1'b0 || appleEaten !== 1'b0) begin
      bad++; $display("FAIL reset_flags: got over=%b busy=%b eat=%b want 0 0 0", gameOver, busy, appleEaten);
    end
  endtask

  task automatic test_move_right();
    int eb, ee, gb, ge;
    apply_reset();
    model_tick(2'b11, 200, 300, eb, ee);
    do_tick(2'b11, 200, 300, 1'b0, gb, ge);
    total++;
    if (snakeLocX[23:0] !== {8'd50, 8'd50, 8'd60} || snakeLocY[26:0] !== {9'd40, 9'd50, 9'd50}) begin
      bad++; $display("FAIL move_right_pos: got x=%h y=%h want x=%h y=%h",
                      snakeLocX[23:0], snakeLocY[26:0], {8'd50, 8'd50, 8'd60}, {9'd40, 9'd50, 9'd50});
    end
    total++;
    if (gb !== 4 || gb !== eb) begin bad++; $display("FAIL move_right_busy: got %0d want 4", gb); end
    total++;
    if (ge !== 0) begin bad++; $display("FAIL move_right_eat: got %0d want 0", ge); end
  endtask

  task automatic test_reversal();
    int eb, ee, gb, ge;
    apply_reset();
    model_tick(2'b00, 200, 300, eb, ee);
    do_tick(2'b00, 200, 300, 1'b0, gb, ge);
    total++;
    if (snakeLocX[7:0] !== 8'd50 || snakeLocY[8:0] !== 9'd60) begin
      bad++; $display("FAIL reversal_head: got (%0d,%0d) want (50,60)", snakeLocX[7:0], snakeLocY[8:0]);
    end
    total++;
    if (snakeLocX !== exp_x() || snakeLocY !== exp_y()) begin
      bad++; $display("FAIL reversal_bus: got y=%h want y=%h", snakeLocY[35:0], exp_y()[35:0]);
    end
  endtask

  task automatic test_eat_grow();
    int eb, ee, gb, ge;
    apply_reset();
    model_tick(2'b01, 50, 60, eb, ee);
    do_tick(2'b01, 50, 60, 1'b0, gb, ge);
    total++;
    if (ge !== 1 || ee !== 1) begin bad++; $display("FAIL eat_pulse: got %0d want 1", ge); end
    total++;
    if (size !== 8'd3) begin bad++; $display("FAIL eat_size_before: got %0d want 3", size); end
    model_tick(2'b01, 200, 300, eb, ee);
    do_tick(2'b01, 200, 300, 1'b0, gb, ge);
    total++;
    if (size !== 8'd4) begin bad++; $display("FAIL grow_size: got %0d want 4", size); end
    total++;
    if (snakeLocX[31:0] !== {4{8'd50}} || snakeLocY[35:0] !== {9'd40, 9'd50, 9'd60, 9'd70}) begin
      bad++; $display("FAIL grow_pos: got x=%h y=%h want y=%h",
                      snakeLocX[31:0], snakeLocY[35:0], {9'd40, 9'd50, 9'd60, 9'd70});
    end
    total++;
    if (gb !== 5 || gb !== eb) begin bad++; $display("FAIL grow_busy: got %0d want 5", gb); end
  endtask

  task automatic test_wall();
    int eb, ee, gb, ge;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      model_tick(2'b10, 200, 300, eb, ee);
      do_tick(2'b10, 200, 300, 1'b0, gb, ge);
    end
    total++;
    if (snakeLocX[7:0] !== 8'd10 || gameOver !== 1'b0) begin
      bad++; $display("FAIL wall_edge: got x=%0d over=%b want 10 0", snakeLocX[7:0], gameOver);
    end
    model_tick(2'b10, 200, 300, eb, ee);
    do_tick(2'b10, 200, 300, 1'b0, gb, ge);
    total++;
    if (gameOver !== 1'b1) begin bad++; $display("FAIL wall_over: got %b want 1", gameOver); end
    total++;
    if (gb !== eb) begin bad++; $display("FAIL wall_busy: got %0d want %0d", gb, eb); end
    total++;
    if (snakeLocX !== exp_x() || snakeLocY !== exp_y() || snakeLocX[7:0] !== 8'd10) begin
      bad++; $display("FAIL wall_frozen: got x=%h want x=%h", snakeLocX[23:0], exp_x()[23:0]);
    end
    for (int i = 0; i < 2; i++) begin
      model_tick(2'b11, 200, 300, eb, ee);
      do_tick(2'b11, 200, 300, 1'b0, gb, ge);
      total++;
      if (gb !== 0 || snakeLocX !== exp_x() || snakeLocY !== exp_y() || gameOver !== 1'b1) begin
        bad++; $display("FAIL wall_ignored: got busy=%0d over=%b want 0 1", gb, gameOver);
      end
    end
  endtask

  task automatic test_self_collision();
    int eb, ee, gb, ge;
    logic [1:0] dirs[8];
    int         axs[8];
    int         ays[8];
    dirs = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b01, 2'b10, 2'b00};
    axs  = '{50, 200, 50, 200, 200, 200, 200, 200};
    ays  = '{60, 300, 80, 300, 300, 300, 300, 300};
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      model_tick(dirs[i], axs[i], ays[i], eb, ee);
      do_tick(dirs[i], axs[i], ays[i], 1'b0, gb, ge);
      if (i == 3) begin
        total++;
        if (size !== 8'd5) begin bad++; $display("FAIL self_grow: got %0d want 5", size); end
      end
    end
    total++;
    if (gameOver !== 1'b1 || m_over !== 1'b1) begin
      bad++; $display("FAIL self_over: got %b want 1", gameOver);
    end
    total++;
    if (gb !== 6 || gb !== eb) begin bad++; $display("FAIL self_busy: got %0d want 6", gb); end
    total++;
    if (snakeLocX !== exp_x() || snakeLocY !== exp_y()) begin
      bad++; $display("FAIL self_bus: got x=%h want x=%h", snakeLocX[39:0], exp_x()[39:0]);
    end
    // Reset during a scan pass.
    apply_reset();
    direction = 2'b11;
    gameTick  = 1'b1;
    @(negedge clock);
    gameTick = 1'b0;
    @(negedge clock);
    @(negedge clock);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL scan_busy: got %b want 1", busy); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    total++;
    if (busy !== 1'b0 || gameOver !== 1'b0 || size !== 8'd3 ||
        snakeLocX !== exp_x() || snakeLocY !== exp_y()) begin
      bad++; $display("FAIL scan_reset: got busy=%b over=%b size=%0d x=%h want 0 0 3 323232",
                      busy, gameOver, size, snakeLocX[23:0]);
    end
  endtask

  task automatic test_back_to_back();
    int eb, ee, gb, ge;
    apply_reset();
    model_tick(2'b11, 200, 300, eb, ee);
    do_tick(2'b11, 200, 300, 1'b1, gb, ge);
    total++;
    if (snakeLocX !== exp_x() || snakeLocY !== exp_y() || gb !== eb) begin
      bad++; $display("FAIL back_to_back: got x=%h busy=%0d want x=%h busy=%0d",
                      snakeLocX[23:0], gb, exp_x()[23:0], eb);
    end
  endtask

  task automatic test_random();
    int eb, ee, gb, ge, ax, ay;
    logic [1:0] d;
    apply_reset();
    for (int t = 0; t < 250; t++) begin
      if (m_over && $urandom_range(0, 2) == 0) apply_reset();
      d = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        ax = mx[0] + $urandom_range(0, 40) - 20;
        ay = my[0] + $urandom_range(0, 40) - 20;
        if (ax < 0) ax = 0;
        if (ax > 255) ax = 255;
        if (ay < 0) ay = 0;
        if (ay > 511) ay = 511;
      end else begin
        ax = $urandom_range(0, 255);
        ay = $urandom_range(0, 511);
      end
      model_tick(d, ax, ay, eb, ee);
      do_tick(d, ax, ay, 1'b0, gb, ge);
      total++;
      if (snakeLocX !== exp_x() || snakeLocY !== exp_y()) begin
        bad++; $display("FAIL rand_bus t=%0d: got x=%h y=%h want x=%h y=%h",
                        t, snakeLocX[63:0], snakeLocY[71:0], exp_x()[63:0], exp_y()[71:0]);
      end
      total++;
      if (size !== 8'(mx.size()) || gameOver !== m_over) begin
        bad++; $display("FAIL rand_state t=%0d: got size=%0d over=%b want %0d %b",
                        t, size, gameOver, mx.size(), m_over);
      end
      total++;
      if (gb !== eb || ge !== ee) begin
        bad++; $display("FAIL rand_timing t=%0d: got busy=%0d eat=%0d want %0d %0d", t, gb, ge, eb, ee);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    gameTick  = 1'b0;
    direction = 2'b01;
    appleLocX = 8'd200;
    appleLocY = 9'd300;
    model_reset();
    @(negedge clock);
    test_reset();
    test_move_right();
    test_reversal();
    test_eat_grow();
    test_wall();
    test_self_collision();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
